sc_spi_dbuf: RTL and testbench

SPI data buffer and transfer sequencer for the SPI protocol engine. It sits directly upstream and downstream of the SPI protocol controller. It holds a 16-word transmit buffer that the controller reads through its transmit word pointer, and a 16-word receive buffer that the controller fills through its receive valid strobe and pointer. It also runs the start/busy handshake, so the host side sees a single start request, a busy flag and a one-cycle done pulse.

---
 rtl/sc_spi_dbuf_pkg.sv | 30 +++
 rtl/sc_spi_dbuf_if.sv | 39 +++
 rtl/sc_spi_dbuf_ram.sv | 51 +++++
 rtl/sc_spi_dbuf.sv | 126 ++++++++++++
 tb/tb_sc_spi_dbuf.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sc_spi_dbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sc_spi_dbuf_pkg
// Brief   : Shared types, sizes and state encoding for the SPI data buffer.
// Revision: 1.0 - initial release
// ============================================================================
package sc_spi_dbuf_pkg;

    localparam int NUM_WORDS = 16;
    localparam int PTR_W     = 4;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    // Receive word count saturates at the buffer depth
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v >= CNT_W'(NUM_WORDS)) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_spi_dbuf_if.sv
`default_nettype none
// ============================================================================
// Module  : sc_spi_dbuf_if
// Brief   : Host and engine signal bundle for the SPI data buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface sc_spi_dbuf_if;
    import sc_spi_dbuf_pkg::*;

    logic  HWE;
    ptr_t  HWADDR;
    word_t HWDATA;
    ptr_t  HRADDR;
    word_t HRDATA;
    logic  HSTART;
    logic  HBUSY;
    logic  HDONE;
    logic  HWERR;
    cnt_t  HRXCNT;
    logic  SPISTART;
    logic  SPIBUSY;
    ptr_t  TXDPT;
    word_t TXDATA;
    word_t RXDATA;
    logic  RXVALID;
    ptr_t  RXDPT;

    modport slave (
        input  HWE, HWADDR, HWDATA, HRADDR, HSTART, SPIBUSY, TXDPT, RXDATA, RXVALID, RXDPT,
        output HRDATA, HBUSY, HDONE, HWERR, HRXCNT, SPISTART, TXDATA
    );

    modport master (
        output HWE, HWADDR, HWDATA, HRADDR, HSTART, SPIBUSY, TXDPT, RXDATA, RXVALID, RXDPT,
        input  HRDATA, HBUSY, HDONE, HWERR, HRXCNT, SPISTART, TXDATA
    );

endinterface
`default_nettype wire

// File: rtl/sc_spi_dbuf_ram.sv
`default_nettype none
// ============================================================================
// Module  : sc_spi_dbuf_ram
// Brief   : 16x32 register file, one write port, combinational or registered read.
// Revision: 1.0 - initial release
// ============================================================================
module sc_spi_dbuf_ram
    import sc_spi_dbuf_pkg::*;
#(
    parameter bit REG_READ = 1'b0
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  i_wen,
    input  wire ptr_t  i_waddr,
    input  wire word_t i_wdata,
    input  wire ptr_t  i_raddr,
    output      word_t o_rdata
);

    word_t r_mem [NUM_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_rd
            // Samples the array before this edge's write: read-before-write
            word_t r_rdata;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= r_mem[i_raddr];
                end
            end
            assign o_rdata = r_rdata;
        end else begin : g_comb_rd
            assign o_rdata = r_mem[i_raddr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sc_spi_dbuf.sv
`default_nettype none
// ============================================================================
// Module  : sc_spi_dbuf
// Brief   : SPI transmit/receive word buffers and start/busy/done sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module sc_spi_dbuf
    import sc_spi_dbuf_pkg::*;
#(
    parameter int DRAIN_CYC = 2
) (
    input wire logic     SPICLK,
    input wire logic     SYSRST,
    sc_spi_dbuf_if.slave bus
);

    localparam int            c_CNT_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam [c_CNT_W-1:0]  c_DRAIN_LOAD = c_CNT_W'(DRAIN_CYC - 1);

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_drain;
    logic               r_spistart;
    logic               r_hbusy;
    logic               r_hdone;
    logic               r_hwerr;
    cnt_t               r_rxcnt;

    logic w_start_acc;
    logic w_tx_wen;

    assign w_start_acc = (r_state == c_ST_IDLE) && bus.HSTART;
    // HBUSY is still low in the accept cycle, so a coincident write lands
    assign w_tx_wen    = bus.HWE && !r_hbusy;

    always_ff @(posedge SPICLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_state    <= c_ST_IDLE;
            r_drain    <= '0;
            r_spistart <= 1'b0;
            r_hbusy    <= 1'b0;
            r_hdone    <= 1'b0;
        end else begin
            r_hdone <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.HSTART) begin
                        r_state    <= c_ST_START;
                        r_spistart <= 1'b1;
                        r_hbusy    <= 1'b1;
                    end
                end
                c_ST_START: begin
                    if (bus.SPIBUSY) begin
                        r_state    <= c_ST_RUN;
                        r_spistart <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    if (!bus.SPIBUSY) begin
                        r_state <= c_ST_DRAIN;
                        r_drain <= c_DRAIN_LOAD;
                    end
                end
                c_ST_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= c_ST_DONE;
                        r_hdone <= 1'b1;
                        r_hbusy <= 1'b0;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_spistart <= 1'b0;
                    r_hbusy    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge SPICLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_rxcnt <= '0;
            r_hwerr <= 1'b0;
        end else begin
            r_hwerr <= bus.HWE && r_hbusy;
            if (w_start_acc) begin
                r_rxcnt <= '0;
            end else if (bus.RXVALID) begin
                r_rxcnt <= sat_inc(r_rxcnt);
            end
        end
    end

    sc_spi_dbuf_ram #(.REG_READ(1'b0)) u_txbuf (
        .clk     (SPICLK),
        .rst     (SYSRST),
        .i_wen   (w_tx_wen),
        .i_waddr (bus.HWADDR),
        .i_wdata (bus.HWDATA),
        .i_raddr (bus.TXDPT),
        .o_rdata (bus.TXDATA)
    );

    sc_spi_dbuf_ram #(.REG_READ(1'b1)) u_rxbuf (
        .clk     (SPICLK),
        .rst     (SYSRST),
        .i_wen   (bus.RXVALID),
        .i_waddr (bus.RXDPT),
        .i_wdata (bus.RXDATA),
        .i_raddr (bus.HRADDR),
        .o_rdata (bus.HRDATA)
    );

    assign bus.SPISTART = r_spistart;
    assign bus.HBUSY    = r_hbusy;
    assign bus.HDONE    = r_hdone;
    assign bus.HWERR    = r_hwerr;
    assign bus.HRXCNT   = r_rxcnt;

endmodule
`default_nettype wire

// File: tb/tb_sc_spi_dbuf.sv
`default_nettype none
// ============================================================================
// Module  : tb_sc_spi_dbuf
// Brief   : Self-checking bench for sc_spi_dbuf with a scripted engine model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sc_spi_dbuf;
    import sc_spi_dbuf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_spi_dbuf_if bus();

    sc_spi_dbuf #(.DRAIN_CYC(2)) dut (
        .SPICLK (clk),
        .SYSRST (rst),
        .bus    (bus)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    word_t tx_model [NUM_WORDS];
    word_t rx_model [NUM_WORDS];
    word_t sb_q [$];
    int    exp_cnt = 0;
    int    n_spistart = 0;
    int    n_hdone = 0;
    int    sp0, hd0;

    always @(negedge clk) begin
        if (bus.SPISTART) n_spistart++;
        if (bus.HDONE)    n_hdone++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input ptr_t a);
        word_t exp;
        bus.HRADDR = a;
        sb_q.push_back(rx_model[a]);
        tick();
        exp = sb_q.pop_front();
        chk($sformatf("hrdata[%0d]", a), bus.HRDATA, exp);
    endtask

    task automatic wr(input ptr_t a, input word_t d);
        bus.HWE    = 1'b1;
        bus.HWADDR = a;
        bus.HWDATA = d;
        tick();
        bus.HWE    = 1'b0;
        tx_model[a] = d;
        bus.TXDPT  = a;
        #1;
        chk($sformatf("txdata[%0d]", a), bus.TXDATA, tx_model[a]);
    endtask

    task automatic rxs(input ptr_t a, input word_t d);
        bus.RXVALID = 1'b1;
        bus.RXDPT   = a;
        bus.RXDATA  = d;
        tick();
        bus.RXVALID = 1'b0;
        rx_model[a] = d;
        if (exp_cnt < NUM_WORDS) exp_cnt++;
        chk("hrxcnt", bus.HRXCNT, exp_cnt);
    endtask

    task automatic start_xfer();
        sp0 = n_spistart;
        hd0 = n_hdone;
        bus.HSTART = 1'b1;
        tick();
        bus.HSTART = 1'b0;
        exp_cnt = 0;
        chk("spistart_c1", bus.SPISTART, 1);
        chk("hbusy_c1", bus.HBUSY, 1);
        chk("hrxcnt_clr", bus.HRXCNT, 0);
        tick();
        chk("spistart_c2", bus.SPISTART, 1);
        bus.SPIBUSY = 1'b1;
        tick();
        chk("spistart_c3", bus.SPISTART, 0);
    endtask

    task automatic end_xfer(input bit late_rx);
        bus.SPIBUSY = 1'b0;
        tick();
        chk("hdone_n1", bus.HDONE, 0);
        if (late_rx) begin
            rxs(4'd7, 32'hC0DE_0007);
        end else begin
            tick();
        end
        chk("hdone_n2", bus.HDONE, 0);
        chk("hbusy_n2", bus.HBUSY, 1);
        tick();
        chk("hdone_n3", bus.HDONE, 1);
        chk("hbusy_n3", bus.HBUSY, 0);
        tick();
        chk("hdone_n4", bus.HDONE, 0);
        chk("spistart_cycles", n_spistart - sp0, 2);
        chk("hdone_pulses", n_hdone - hd0, 1);
    endtask

    initial begin
        bus.HWE = 1'b0; bus.HWADDR = '0; bus.HWDATA = '0; bus.HRADDR = '0;
        bus.HSTART = 1'b0; bus.SPIBUSY = 1'b0; bus.TXDPT = '0;
        bus.RXDATA = '0; bus.RXVALID = 1'b0; bus.RXDPT = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            tx_model[i] = '0;
            rx_model[i] = '0;
        end

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_spistart", bus.SPISTART, 0);
        chk("rst_hbusy", bus.HBUSY, 0);
        chk("rst_hdone", bus.HDONE, 0);
        chk("rst_hwerr", bus.HWERR, 0);
        chk("rst_hrxcnt", bus.HRXCNT, 0);
        chk("rst_txdata", bus.TXDATA, 0);
        for (int i = 0; i < NUM_WORDS; i++) rd(ptr_t'(i));

        wr(4'd3, 32'hA5A5_0F0F);
        wr(4'd9, 32'h0123_4567);
        bus.TXDPT = 4'd3;
        #1;
        chk("txdata_sel3", bus.TXDATA, 32'hA5A5_0F0F);

        // Transfer 1: four receive words, blocked host write, ignored restart
        start_xfer();
        for (int i = 0; i < 4; i++) rxs(ptr_t'(i), 32'h1111_1111 * i);
        repeat (20) tick();
        bus.HWE = 1'b1; bus.HWADDR = 4'd3; bus.HWDATA = 32'hDEAD_BEEF;
        tick();
        bus.HWE = 1'b0;
        chk("hwerr_pulse", bus.HWERR, 1);
        tick();
        chk("hwerr_clear", bus.HWERR, 0);
        bus.TXDPT = 4'd3;
        #1;
        chk("txbuf_kept", bus.TXDATA, tx_model[3]);
        bus.HSTART = 1'b1;
        tick();
        bus.HSTART = 1'b0;
        repeat (10) tick();
        end_xfer(1'b0);
        chk("hrxcnt_4", bus.HRXCNT, 4);
        rd(4'd2);
        rd(4'd0);
        rd(4'd3);
        wr(4'd3, 32'h1234_5678);

        // Transfer 2: a receive word lands during drain
        start_xfer();
        repeat (5) tick();
        end_xfer(1'b1);
        rd(4'd7);

        // Transfer 3: saturation of the receive count
        start_xfer();
        for (int i = 0; i < 17; i++) begin
            word_t d;
            d = $urandom;
            rxs(ptr_t'(i % 16), d);
        end
        end_xfer(1'b0);
        chk("hrxcnt_sat", bus.HRXCNT, 16);
        rd(4'd0);
        rd(4'd15);

        // Reset while SPISTART is high
        bus.HSTART = 1'b1;
        tick();
        bus.HSTART = 1'b0;
        chk("pre_rst_spistart", bus.SPISTART, 1);
        rst = 1'b1;
        #1;
        chk("rst_start_spistart", bus.SPISTART, 0);
        chk("rst_start_hbusy", bus.HBUSY, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            tx_model[i] = '0;
            rx_model[i] = '0;
        end
        tick();

        // Reset mid-run
        start_xfer();
        rxs(4'd5, 32'h5555_AAAA);
        rxs(4'd6, 32'h6666_BBBB);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_run_spistart", bus.SPISTART, 0);
        chk("rst_run_hbusy", bus.HBUSY, 0);
        chk("rst_run_hrxcnt", bus.HRXCNT, 0);
        for (int i = 0; i < NUM_WORDS; i++) begin
            tx_model[i] = '0;
            rx_model[i] = '0;
        end
        exp_cnt = 0;
        bus.SPIBUSY = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rd(4'd5);
        rd(4'd6);
        bus.TXDPT = 4'd3;
        #1;
        chk("rst_txbuf", bus.TXDATA, tx_model[3]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
